uart_lite_responder: RTL

AXI4-lite slave with the UartLite register map (RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC), the responder for the CPU's `uart_rx`/`uart_tx` master ports. It buffers bytes in an RX FIFO filled from a byte-stream input and a TX FIFO drained to a byte-stream output. It serves as the simulation/bring-up stand-in for the UART IP, and as the front end for a custom serial PHY.

---
 rtl/uart_lite_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_lite_responder.sv
// uart_lite_responder: AXI4-lite UartLite register front end with RX/TX byte FIFOs.
// Optional macro UART_LITE_IRQ_EN enables the level interrupt, CTRL irq enable and STAT bit4.
module uart_lite_responder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [3:0]  axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_push,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    // state  | meaning
    // R_IDLE | accepting a read address
    // R_RESP | holding read data until rready
    // W_IDLE | accepting write address and data together
    // W_RESP | holding write response until bready

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    typedef enum logic {W_IDLE, W_RESP} w_state_t;

    r_state_t r_state;
    w_state_t w_state;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic          rx_empty, rx_full, tx_empty, tx_full;
    logic          rx_overrun, irq_en;
    logic          rd_hs, wr_hs, rx_pop, stat_rd, ctrl_wr;
    logic          rx_clr, tx_clr, rx_wr, rx_ovr_set, tx_push_req, tx_pop, tx_wr;
    logic [7:0]    rx_head;
    logic [31:0]   stat, rd_data;
    logic [1:0]    rd_resp, wr_resp;
    logic          unused_bits;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);

    assign rd_hs   = axi_arvalid && axi_arready;
    assign wr_hs   = axi_awvalid && axi_wvalid && axi_awready;
    assign rx_pop  = rd_hs && (axi_araddr == 4'h0) && !rx_empty;
    assign stat_rd = rd_hs && (axi_araddr == 4'h8);
    assign ctrl_wr = wr_hs && (axi_awaddr == 4'hC);
    assign rx_clr  = ctrl_wr && axi_wdata[1];
    assign tx_clr  = ctrl_wr && axi_wdata[0];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign rx_wr       = rx_push && (!rx_full || rx_pop) && !rx_clr;
    assign rx_ovr_set  = rx_push && rx_full && !rx_pop && !rx_clr;
    assign tx_push_req = wr_hs && (axi_awaddr == 4'h4) && axi_wstrb[0];
    assign tx_pop      = !tx_empty && tx_ready;
    assign tx_wr       = tx_push_req && (!tx_full || tx_pop) && !tx_clr;

    assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
    assign tx_valid = !tx_empty;
    assign tx_byte  = tx_empty ? 8'h00 : tx_mem[tx_rp[AW-1:0]];
    assign stat     = {26'h0, rx_overrun, irq_en, tx_full, tx_empty, rx_full, !rx_empty};
    assign wr_resp  = ((axi_awaddr == 4'h4) || (axi_awaddr == 4'hC)) ? 2'b00 : 2'b10;
    assign unused_bits = ^{axi_wdata[31:8], axi_wstrb[3:1]};

    always_comb begin
        rd_data = 32'h0;
        rd_resp = 2'b00;
        case (axi_araddr)
            4'h0:    rd_data = {24'h0, rx_head};
            4'h8:    rd_data = stat;
            default: rd_resp = 2'b10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= rx_byte;
        if (tx_wr) tx_mem[tx_wp[AW-1:0]] <= axi_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wp      <= '0;
            rx_rp      <= '0;
            tx_wp      <= '0;
            tx_rp      <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_clr) begin
                rx_wp <= '0;
                rx_rp <= '0;
            end else begin
                if (rx_wr)  rx_wp <= rx_wp + PW'(1);
                if (rx_pop) rx_rp <= rx_rp + PW'(1);
            end
            if (tx_clr) begin
                tx_wp <= '0;
                tx_rp <= '0;
            end else begin
                if (tx_wr)  tx_wp <= tx_wp + PW'(1);
                if (tx_pop) tx_rp <= tx_rp + PW'(1);
            end
            // A same-cycle overrun outranks the STAT read clear.
            if (rx_ovr_set)   rx_overrun <= 1'b1;
            else if (stat_rd) rx_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= R_IDLE;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= 32'h0;
            axi_rresp   <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    axi_arready <= 1'b1;
                    if (rd_hs) begin
                        r_state     <= R_RESP;
                        axi_arready <= 1'b0;
                        axi_rvalid  <= 1'b1;
                        axi_rdata   <= rd_data;
                        axi_rresp   <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        r_state     <= R_IDLE;
                        axi_rvalid  <= 1'b0;
                        axi_arready <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state     <= W_IDLE;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    axi_awready <= 1'b1;
                    axi_wready  <= 1'b1;
                    if (wr_hs) begin
                        w_state     <= W_RESP;
                        axi_awready <= 1'b0;
                        axi_wready  <= 1'b0;
                        axi_bvalid  <= 1'b1;
                        axi_bresp   <= wr_resp;
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        w_state     <= W_IDLE;
                        axi_bvalid  <= 1'b0;
                        axi_awready <= 1'b1;
                        axi_wready  <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef UART_LITE_IRQ_EN
    logic tx_empty_event, tx_goes_empty, irq_q;

    assign tx_goes_empty = !tx_empty &&
                           (tx_clr || (tx_pop && !tx_wr && ((tx_wp - tx_rp) == PW'(1))));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_en         <= 1'b0;
            tx_empty_event <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= axi_wdata[4];
            if (tx_goes_empty) tx_empty_event <= 1'b1;
            else if (stat_rd)  tx_empty_event <= 1'b0;
            irq_q <= irq_en && (!rx_empty || tx_empty_event);
        end
    end

    assign irq = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule
